// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared constants and FSM state type for the sprite line
//                scheduler (sprite geometry, VGA timing, ROM address width).
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

   localparam int SPRITE_W = 16;
   localparam int SPRITE_H = 16;
   localparam int H_ACTIVE = 640;
   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;
   localparam int ROM_AW   = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_FETCH = 2'd2,
      ST_NEXT  = 2'd3
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_line_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_scheduler_if
//  Description : Sprite ROM port and per-pixel sprite result bundle.
//                master = scheduler side, slave = ROM / video mixer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_line_scheduler_if;
   import sprite_pkg::*;

   logic [ROM_AW-1:0] rom_address;
   logic [2:0]        rom_q;
   logic [2:0]        pix_index;
   logic              pix_valid;
   logic [2:0]        pix_slot;

   modport master (
      output rom_address,
      input  rom_q,
      output pix_index,
      output pix_valid,
      output pix_slot
   );

   modport slave (
      input  rom_address,
      output rom_q,
      input  pix_index,
      input  pix_valid,
      input  pix_slot
   );
endinterface
`default_nettype wire

// File: rtl/sprite_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_buffer
//  Description : Double-buffered line store: one 16-pixel row of 3-bit palette
//                indices per sprite slot, plus per-slot valid bit and x
//                position. The scheduler fills the shadow copy; the swap strobe
//                moves it to the active copy and empties the shadow.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_buffer
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 5
) (
   input  logic                                      vga_clk,
   input  logic                                      reset_n,
   input  logic                                      wr_en,
   input  logic [2:0]                                wr_slot,
   input  logic [3:0]                                wr_col,
   input  logic [2:0]                                wr_data,
   input  logic                                      set_valid,
   input  logic [2:0]                                set_slot,
   input  logic [9:0]                                set_x,
   input  logic                                      swap,
   output logic [NUM_SPRITES-1:0]                    act_valid,
   output logic [NUM_SPRITES-1:0][9:0]               act_x,
   output logic [NUM_SPRITES-1:0][SPRITE_W-1:0][2:0] act_pix
);

   logic [NUM_SPRITES-1:0][SPRITE_W-1:0][2:0] r_shadow_pix;
   logic [NUM_SPRITES-1:0][SPRITE_W-1:0][2:0] r_active_pix;
   logic [NUM_SPRITES-1:0]                    r_shadow_valid;
   logic [NUM_SPRITES-1:0]                    r_active_valid;
   logic [NUM_SPRITES-1:0][9:0]               r_shadow_x;
   logic [NUM_SPRITES-1:0][9:0]               r_active_x;

   // Pixel storage: contents are meaningless without the valid bits, so no reset.
   always_ff @(posedge vga_clk) begin
      if (swap) begin
         r_active_pix <= r_shadow_pix;
      end
      if (wr_en) begin
         r_shadow_pix[wr_slot][wr_col] <= wr_data;
      end
   end

   // Valid bits and x latches; swap hands the shadow line over and empties it.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shadow_valid <= '0;
         r_active_valid <= '0;
         r_shadow_x     <= '0;
         r_active_x     <= '0;
      end else begin
         if (swap) begin
            r_active_valid <= r_shadow_valid;
            r_active_x     <= r_shadow_x;
            r_shadow_valid <= '0;
         end
         if (set_valid) begin
            r_shadow_valid[set_slot] <= 1'b1;
            r_shadow_x[set_slot]     <= set_x;
         end
      end
   end

   assign act_valid = r_active_valid;
   assign act_x     = r_active_x;
   assign act_pix   = r_active_pix;

endmodule
`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_scheduler
//  Description : During horizontal blanking, scans all sprite slots for the
//                next raster line and fetches each hit sprite's 16-pixel row
//                from the shared sprite ROM into a shadow line buffer. At the
//                end of the line the shadow becomes active, and the active
//                line is composited per pixel (lowest opaque slot wins).
//                Optional feature macro: SPRITE_HFLIP_EN (adds spr_hflip input
//                for per-slot horizontal mirroring).
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_scheduler
   import sprite_pkg::*;
#(
   parameter int         NUM_SPRITES     = 5,
   parameter logic [2:0] TRANSPARENT_IDX = 3'd0
) (
   input  logic                         vga_clk,
   input  logic                         reset_n,
   input  logic [9:0]                   DrawX,
   input  logic [9:0]                   DrawY,
   input  logic                         blank,
   input  logic [NUM_SPRITES-1:0]       spr_en,
   input  logic [NUM_SPRITES-1:0][9:0]  spr_x,
   input  logic [NUM_SPRITES-1:0][9:0]  spr_y,
   input  logic [NUM_SPRITES-1:0][2:0]  spr_img,
`ifdef SPRITE_HFLIP_EN
   input  logic [NUM_SPRITES-1:0]       spr_hflip,
`endif
   sprite_line_scheduler_if.master      bus
);

   localparam logic [2:0] c_last_slot = 3'(NUM_SPRITES - 1);

   sched_state_t      r_state;
   logic [2:0]        r_k;
   logic [9:0]        r_target;
   logic [3:0]        r_row;
   logic [2:0]        r_img;
   logic              r_flip;
   logic [3:0]        r_col;
   logic [9:0]        r_x;
   logic              r_hit;
   logic [ROM_AW-1:0] r_rom_address;
   logic              r_wr_en;
   logic [3:0]        r_wr_col;
   logic [2:0]        r_pix_index;
   logic              r_pix_valid;
   logic [2:0]        r_pix_slot;

   logic [9:0]        w_dy;
   logic              w_hit;
   logic              w_flip_in;
   logic              w_line_end;
   logic              w_hblank_start;
   logic [9:0]        w_next_target;
   logic              w_set_valid;

   logic [NUM_SPRITES-1:0]                    w_act_valid;
   logic [NUM_SPRITES-1:0][9:0]               w_act_x;
   logic [NUM_SPRITES-1:0][SPRITE_W-1:0][2:0] w_act_pix;

   logic              w_found;
   logic [2:0]        w_win_idx;
   logic [2:0]        w_win_slot;
   logic [9:0]        w_dx;
   logic [2:0]        w_cand;

`ifdef SPRITE_HFLIP_EN
   assign w_flip_in = spr_hflip[r_k];
`else
   assign w_flip_in = 1'b0;
`endif

   // Vertical hit test is modulo 1024 so sprites partly above the top edge still work.
   assign w_dy           = r_target - spr_y[r_k];
   assign w_hit          = spr_en[r_k] && (w_dy[9:4] == 6'd0);
   assign w_line_end     = (DrawX == 10'(H_TOTAL - 1));
   assign w_hblank_start = (DrawX == 10'(H_ACTIVE));
   assign w_next_target  = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
   // A slot completing on the swap cycle itself missed the deadline.
   assign w_set_valid    = (r_state == ST_NEXT) && r_hit && !w_line_end;

   // Scheduler FSM: scan slots, fetch hit rows, abort anything unfinished at line end.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_k           <= '0;
         r_target      <= '0;
         r_row         <= '0;
         r_img         <= '0;
         r_flip        <= 1'b0;
         r_col         <= '0;
         r_x           <= '0;
         r_hit         <= 1'b0;
         r_rom_address <= '0;
         r_wr_en       <= 1'b0;
         r_wr_col      <= '0;
      end else begin
         r_wr_en  <= 1'b0;
         r_wr_col <= r_col;
         if (w_line_end) begin
            r_state       <= ST_IDLE;
            r_k           <= '0;
            r_hit         <= 1'b0;
            r_rom_address <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_hblank_start) begin
                     r_state  <= ST_SCAN;
                     r_target <= w_next_target;
                     r_k      <= '0;
                  end
               end
               ST_SCAN: begin
                  r_hit  <= w_hit;
                  r_img  <= spr_img[r_k];
                  r_row  <= w_dy[3:0];
                  r_flip <= w_flip_in;
                  r_x    <= spr_x[r_k];
                  r_col  <= '0;
                  if (w_hit) begin
                     r_state       <= ST_FETCH;
                     r_rom_address <= {spr_img[r_k], w_dy[3:0], (w_flip_in ? 4'hF : 4'h0)};
                  end else begin
                     r_state <= ST_NEXT;
                  end
               end
               ST_FETCH: begin
                  // rom_q for the address now on the bus is written next cycle.
                  r_wr_en <= 1'b1;
                  if (r_col == 4'hF) begin
                     r_state       <= ST_NEXT;
                     r_rom_address <= '0;
                  end else begin
                     r_col         <= r_col + 4'd1;
                     r_rom_address <= {r_img, r_row,
                                       (r_flip ? ~(r_col + 4'd1) : (r_col + 4'd1))};
                  end
               end
               ST_NEXT: begin
                  r_hit <= 1'b0;
                  if (r_k == c_last_slot) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_k     <= r_k + 3'd1;
                     r_state <= ST_SCAN;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   sprite_line_buffer #(
      .NUM_SPRITES (NUM_SPRITES)
   ) u_line_buffer (
      .vga_clk   (vga_clk),
      .reset_n   (reset_n),
      .wr_en     (r_wr_en),
      .wr_slot   (r_k),
      .wr_col    (r_wr_col),
      .wr_data   (bus.rom_q),
      .set_valid (w_set_valid),
      .set_slot  (r_k),
      .set_x     (r_x),
      .swap      (w_line_end),
      .act_valid (w_act_valid),
      .act_x     (w_act_x),
      .act_pix   (w_act_pix)
   );

   // Priority composite: walk slots high to low so the lowest opaque slot overrides.
   always_comb begin
      w_found    = 1'b0;
      w_win_idx  = '0;
      w_win_slot = '0;
      w_dx       = '0;
      w_cand     = '0;
      for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
         w_dx   = DrawX - w_act_x[s];
         w_cand = w_act_pix[s][w_dx[3:0]];
         if (w_act_valid[s] && (w_dx[9:4] == 6'd0) && (w_cand != TRANSPARENT_IDX)) begin
            w_found    = 1'b1;
            w_win_idx  = w_cand;
            w_win_slot = 3'(s);
         end
      end
   end

   // Registered pixel result, one cycle behind DrawX.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_index <= '0;
         r_pix_valid <= 1'b0;
         r_pix_slot  <= '0;
      end else begin
         r_pix_index <= w_win_idx;
         r_pix_valid <= w_found && blank;
         r_pix_slot  <= w_win_slot;
      end
   end

   assign bus.rom_address = r_rom_address;
   assign bus.pix_index   = r_pix_index;
   assign bus.pix_valid   = r_pix_valid;
   assign bus.pix_slot    = r_pix_slot;

endmodule
`default_nettype wire
